// File: rtl/cache_mem_bridge.sv
// Block-to-word sequencer between the L1 miss port and a word-wide RAM.
// Optional posted writeback drain buffer: define BRIDGE_WB_BUFFER_EN.
module cache_mem_bridge #(
  parameter int BLOCKS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [31:0]            mem_addr,
  input  logic [BLOCKS*32-1:0]   mem_write_block,
  output logic [BLOCKS*32-1:0]   mem_read_block,
  output logic                   mem_miss,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [31:0]            ram_addr,
  output logic [31:0]            ram_write_word,
  input  logic [31:0]            ram_read_word,
  input  logic                   ram_miss
);

  localparam int IDX_W = $clog2(BLOCKS);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [31:0]       wr_words_reg [BLOCKS];
  logic [31:0]       wr_in [BLOCKS];
  logic [IDX_W-1:0]  idx_next;
  logic [31:0]       base_addr;
  logic              last_word;
  logic              launch_ok;
  logic              unused_addr_bits;

  assign idx_next         = idx_reg + 1'b1;
  assign last_word        = (idx_reg == LAST_IDX);
  assign base_addr        = {mem_addr[31:OFF_W], OFF_W'(0)};
  assign unused_addr_bits = ^mem_addr[OFF_W-1:0];
  assign mem_miss         = mem_req && (state_reg != DONE);

  genvar gi;
  generate
    for (gi = 0; gi < BLOCKS; gi++) begin : g_word
      logic [31:0] rd_word_reg;

      assign wr_in[gi] = mem_write_block[gi*32 +: 32];
      assign mem_read_block[gi*32 +: 32] = rd_word_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset)
          rd_word_reg <= '0;
        else if (state_reg == RD && !ram_miss && idx_reg == IDX_W'(gi))
          rd_word_reg <= ram_read_word;
      end
    end
  endgenerate

`ifdef BRIDGE_WB_BUFFER_EN
  logic drain_busy_reg;
  // A new request must wait for the drain so a refill sees the posted data.
  assign launch_ok = !drain_busy_reg;
`else
  assign launch_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      ram_req        <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_write_word <= '0;
      for (int i = 0; i < BLOCKS; i++) wr_words_reg[i] <= '0;
`ifdef BRIDGE_WB_BUFFER_EN
      drain_busy_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_req && launch_ok) begin
            idx_reg        <= '0;
            ram_req        <= 1'b1;
            ram_we         <= mem_we;
            ram_addr       <= base_addr;
            ram_write_word <= wr_in[0];
            if (mem_we) begin
              for (int i = 0; i < BLOCKS; i++) wr_words_reg[i] <= wr_in[i];
`ifdef BRIDGE_WB_BUFFER_EN
              drain_busy_reg <= 1'b1;
              state_reg      <= DONE;
`else
              state_reg      <= WR;
`endif
            end else begin
              state_reg <= RD;
            end
          end
        end
        WR, RD: begin
          if (!ram_miss) begin
            if (last_word) begin
              state_reg <= DONE;
              ram_req   <= 1'b0;
              ram_we    <= 1'b0;
            end else begin
              idx_reg        <= idx_next;
              ram_addr       <= ram_addr + 32'd4;
              ram_write_word <= wr_words_reg[idx_next];
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
`ifdef BRIDGE_WB_BUFFER_EN
      // Background drain owns the RAM port while the FSM sits in DONE/IDLE.
      if (drain_busy_reg && !ram_miss) begin
        if (last_word) begin
          drain_busy_reg <= 1'b0;
          ram_req        <= 1'b0;
          ram_we         <= 1'b0;
        end else begin
          idx_reg        <= idx_next;
          ram_addr       <= ram_addr + 32'd4;
          ram_write_word <= wr_words_reg[idx_next];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge with a word-wide RAM model (unwritten word = its address).
module tb_cache_mem_bridge;
  localparam int BLOCKS = 4;

  logic                  clock;
  logic                  reset;
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [BLOCKS*32-1:0]  mem_write_block;
  logic [BLOCKS*32-1:0]  mem_read_block;
  logic                  mem_miss;
  logic                  ram_req;
  logic                  ram_we;
  logic [31:0]           ram_addr;
  logic [31:0]           ram_write_word;
  logic [31:0]           ram_read_word;
  logic                  ram_miss;

  int n_tests;
  int n_fail;

  bit [31:0] ram_data  [16384];
  bit        ram_valid [16384];

  logic [31:0] seen [16];
  int          n_seen;
  int          stall_left;
  logic [31:0] stall_addr;

  cache_mem_bridge #(.BLOCKS(BLOCKS)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_block(mem_write_block),
    .mem_read_block (mem_read_block),
    .mem_miss       (mem_miss),
    .ram_req        (ram_req),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_write_word (ram_write_word),
    .ram_read_word  (ram_read_word),
    .ram_miss       (ram_miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ram_read_word = ram_valid[ram_addr[15:2]] ? ram_data[ram_addr[15:2]] : ram_addr;

  always @(posedge clock) begin
    if (ram_req && ram_we && !ram_miss) begin
      ram_data[ram_addr[15:2]]  <= ram_write_word;
      ram_valid[ram_addr[15:2]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 of the request.
  task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [127:0] blk,
                         input int toggle_cyc, output int dc);
    int cyc;
    mem_req = 1'b1;
    mem_we = we;
    mem_addr = addr;
    mem_write_block = blk;
    n_seen = 0;
    dc = -1;
    cyc = 0;
    while (dc < 0 && cyc < 40) begin
      if (cyc == toggle_cyc) begin
        mem_addr = 32'h0000_9000;
        mem_we = ~we;
      end
      ram_miss = ram_req && (ram_addr == stall_addr) && (stall_left > 0);
      if (ram_miss) stall_left--;
      @(negedge clock);
      if (cyc == 0) check("miss_in_cycle0", mem_miss, 1'b1);
      if (ram_req && !ram_miss && n_seen < 16) begin
        seen[n_seen] = ram_addr;
        n_seen++;
      end
      if (!mem_miss) dc = cyc;
      else begin
        @(posedge clock);
        #1;
        cyc++;
      end
    end
    $display("[TB] %s addr=0x%08h done in cycle %0d", we ? "writeback" : "refill", addr, dc);
    @(posedge clock);
    #1;
    mem_req = 1'b0;
    mem_we = 1'b0;
    ram_miss = 1'b0;
  endtask

  initial begin
    int dc;
    logic exp_req;
    n_tests = 0;
    n_fail = 0;
    reset = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_write_block = '0;
    ram_miss = 1'b0;
    stall_left = 0;
    stall_addr = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_ram_req", ram_req, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_write_word, 32'h0);
    check("rst_read_block", mem_read_block, 128'h0);
    mem_req = 1'b1;
    #1;
    check("rst_miss_follows_req", mem_miss, 1'b1);
    mem_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Refill, zero-wait RAM
    do_xfer(1'b0, 32'h0000_1234, '0, -1, dc);
    check("t1_done_cycle", dc, 5);
    check("t1_nwords", n_seen, 4);
    for (int i = 0; i < 4; i++) check("t1_ram_addr", seen[i], 32'h1230 + 32'(4 * i));
    check("t1_block", mem_read_block, {32'h123C, 32'h1238, 32'h1234, 32'h1230});

`ifndef BRIDGE_WB_BUFFER_EN
    // Writeback with a two-cycle stall on word 1
    stall_addr = 32'h0000_2004;
    stall_left = 2;
    do_xfer(1'b1, 32'h0000_2000, {32'hD, 32'hC, 32'hB, 32'hA}, -1, dc);
    check("t2_done_cycle", dc, 7);
    check("t2_stall_consumed", stall_left, 0);
    check("t2_nwords", n_seen, 4);
    check("t2_word1_addr", seen[1], 32'h2004);
    check("t2_ram_2000", ram_data[32'h2000 >> 2], 32'hA);
    check("t2_ram_2004", ram_data[32'h2004 >> 2], 32'hB);
    check("t2_ram_2008", ram_data[32'h2008 >> 2], 32'hC);
    check("t2_ram_200c", ram_data[32'h200C >> 2], 32'hD);
    stall_addr = '0;

    // Back-to-back writeback then refill with mem_req held high
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h0000_3000;
    mem_write_block = {32'h33, 32'h22, 32'h11, 32'h00};
    for (int c = 0; c < 12; c++) begin
      if (c == 6) begin
        mem_we = 1'b0;
        mem_addr = 32'h0000_4000;
      end
      @(negedge clock);
      exp_req = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      check("t3_ram_req", ram_req, exp_req);
      check("t3_mem_miss", mem_miss, (c != 5 && c != 11));
      @(posedge clock);
      #1;
    end
    mem_req = 1'b0;
    $display("[TB] back-to-back writeback 0x3000 / refill 0x4000 over 12 cycles");
    check("t3_ram_3004", ram_data[32'h3004 >> 2], 32'h11);
    check("t3_ram_300c", ram_data[32'h300C >> 2], 32'h33);
    check("t3_block", mem_read_block, {32'h400C, 32'h4008, 32'h4004, 32'h4000});
`endif

    // Reset during the second refill word cycle
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h0000_1234;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("t4_ram_req_async", ram_req, 1'b0);
    check("t4_block_cleared", mem_read_block, 128'h0);
    check("t4_miss_in_reset", mem_miss, 1'b1);
    mem_req = 1'b0;
    $display("[TB] reset asserted mid-refill 0x1234");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_xfer(1'b0, 32'h0000_1234, '0, -1, dc);
    check("t4_rerequest_done", dc, 5);
    check("t4_rerequest_block", mem_read_block, {32'h123C, 32'h1238, 32'h1234, 32'h1230});

    // Request inputs changed mid-refill are ignored
    do_xfer(1'b0, 32'h0000_6008, '0, 2, dc);
    check("t5_done_cycle", dc, 5);
    check("t5_last_addr", seen[3], 32'h600C);
    check("t5_block", mem_read_block, {32'h600C, 32'h6008, 32'h6004, 32'h6000});
    check("t5_no_write_9000", ram_valid[32'h9000 >> 2], 1'b0);

`ifdef BRIDGE_WB_BUFFER_EN
    // Posted writeback, then immediate refill of the same block
    do_xfer(1'b1, 32'h0000_5000, {32'h5D, 32'h5C, 32'h5B, 32'h5A}, -1, dc);
    check("t6_wb_done_cycle", dc, 1);
    do_xfer(1'b0, 32'h0000_5000, '0, -1, dc);
    check("t6_refill_done_cycle", dc, 8);
    check("t6_refill_block", mem_read_block, {32'h5D, 32'h5C, 32'h5B, 32'h5A});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_bridge.md
# cache_mem_bridge

Block-to-word transfer sequencer between the L1 `cache_module` miss port (single-ported L2 interface) and the word-wide `ram_memory_model`. It turns each cache block request (writeback or refill) into BLOCKS sequential RAM word accesses. It assembles refill words into `mem_read_block` and holds `mem_miss` high until the block transfer is done. An optional posted-writeback buffer lets the cache continue while a dirty block drains.

## Interface
- BLOCKS, 4: 32-bit words per cache block; power of two, 2..16.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- mem_req  in  1  cache requests a block transfer.
- mem_we  in  1  1 = writeback of `mem_write_block`, 0 = refill.
- mem_addr  in  32  any byte address inside the target block.
- mem_write_block  in  BLOCKS×32  writeback data, word 0 = lowest address.
- mem_read_block  out  BLOCKS×32  refill data; valid in the DONE cycle and held until the next refill.
- mem_miss  out  1  1 = transfer not yet complete.
- ram_req  out  1  word access request.
- ram_we  out  1  1 = word write.
- ram_addr  out  32  word-aligned byte address.
- ram_write_word  out  32  write data.
- ram_read_word  in  32  read data; valid in the cycle ram_req=1 and ram_miss=0.
- ram_miss  in  1  RAM busy; a word completes only in a cycle with ram_req=1 and ram_miss=0.

## Operation
- Block base address = mem_addr with the low log2(BLOCKS)+2 bits cleared. Word i goes to base + 4·i, for i = 0..BLOCKS-1, in ascending order.
- States and transitions:
  - IDLE: if mem_req=1, latch base, mem_we and mem_write_block. Go to WR if mem_we=1, RD otherwise.
  - WR: ram_req=1, ram_we=1, ram_write_word = latched word[idx]. idx advances when ram_miss=0. After the last word, go to DONE.
  - RD: ram_req=1, ram_we=0. On each completed word, write ram_read_word into mem_read_block[idx] and advance idx. After the last word, go to DONE.
  - DONE: one cycle, then IDLE.
- mem_miss = mem_req AND (state ≠ DONE). This is combinational, so mem_miss is high in the cycle mem_req first rises.
- The DONE cycle is the acknowledge. In the cycle after DONE, the cache either drops mem_req or presents its next request. A writeback followed by a refill with mem_req held high runs back-to-back.
- Request inputs are sampled only in IDLE. Changes to them during WR or RD are ignored.
- ram_addr and ram_write_word are registered and stable while ram_miss=1.
- idx is a log2(BLOCKS)-bit counter and is cleared on entry to WR or RD. Overflow is impossible because the transition to DONE happens when idx = BLOCKS-1 completes.
- Reset values: state IDLE, idx 0, ram_req 0, ram_we 0, ram_addr 0, ram_write_word 0, mem_read_block 0. mem_miss equals mem_req while reset is asserted.
- Reset mid-transfer aborts the transfer. ram_req drops asynchronously and partial refill data is cleared. The cache must re-request after reset.

## Timing
- Zero-wait RAM (ram_miss held 0), request rising in cycle 0:
  - ram_req is high in cycles 1..BLOCKS.
  - DONE, with mem_miss=0, is in cycle BLOCKS+1.
  - Each ram_miss=1 cycle adds one cycle.
- Back-to-back writeback then refill takes 2·(BLOCKS+2) cycles.
- ram_req goes low only in DONE and IDLE cycles.

## Configuration
- BRIDGE_WB_BUFFER_EN defined:
  - A writeback is captured into a BLOCKS×32 drain buffer in IDLE, and the next cycle is DONE (mem_miss=0 one cycle after mem_req).
  - The buffer drains word-serially in the background.
  - A request arriving while the buffer drains holds mem_miss high. It is launched only after the drain completes, so a refill of the same block reads the written-back data.
- BRIDGE_WB_BUFFER_EN undefined: writebacks are blocking, as described in Operation, and no drain buffer exists.

## Test plan
- Refill with BLOCKS=4, mem_addr=0x0000_1234, RAM preloaded with word = address -> ram_addr sequence 0x1230, 0x1234, 0x1238, 0x123C. mem_read_block = {0x123C, 0x1238, 0x1234, 0x1230}. DONE in cycle 5.
- Writeback of {0xD, 0xC, 0xB, 0xA} to 0x2000 with ram_miss=1 for 2 cycles on word 1 -> RAM holds 0xA/0xB/0xC/0xD at 0x2000..0x200C. ram_addr stays 0x2004 while stalled. mem_miss falls in cycle 7.
- Writeback 0x3000 then refill 0x4000 with mem_req held high -> no idle RAM gap beyond the DONE and IDLE cycles. Total 12 cycles.
- Reset asserted in the 2nd RD word cycle -> ram_req=0 and mem_read_block=0 immediately. Re-request after release succeeds.
- Request inputs toggled mid-RD (mem_addr to 0x9000) -> the transfer still completes for the originally latched block.
- With BRIDGE_WB_BUFFER_EN: writeback 0x5000 then an immediate refill of 0x5000 -> writeback mem_miss falls in cycle 1. The refill returns the written-back data after the drain.
